// File: rtl/bcd_scan_display_pkg.sv
// Shared segment constants and helpers for the BCD scan display.
package bcd_scan_display_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Non-BCD nibbles render as a dash so corrupt input is visible on the board.
  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  // True when any of the four nibbles is outside 0..9.
  function automatic logic has_non_bcd(input logic [15:0] val);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (val[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational nibble-to-segment converter with a blank override.
// Usable on its own for a static single-digit display.
module bcd_seg_decode
  import bcd_scan_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // Blank wins over the digit value
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) o_seg = nibble_to_seg(i_nibble);
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Four-digit multiplexed 7-segment driver for a packed-BCD value.
// A snapshot of the input is taken once per scan frame so a frame never
// mixes digits from two different input values.
module bcd_scan_display
  import bcd_scan_display_pkg::*;
#(
  parameter int DIV      = 50000,
  parameter int GUARD    = 1,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_dec,
  output logic [3:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_frame,
  output logic        o_err
);

  localparam int             PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);
  localparam logic [PW:0]    GUARD_W  = (PW + 1)'(GUARD);

  logic [PW-1:0] r_pre;
  logic [1:0]    r_idx;
  logic [15:0]   r_snap;

  logic          w_slot_end;
  logic          w_frame_end;
  logic          w_guard;
  logic          w_blank;
  logic [3:0]    w_nib;
  logic [3:0]    w_an;
  logic [6:0]    w_seg_dec;
  logic [6:0]    w_seg;

  bcd_seg_decode u_decode (
    .i_nibble (w_nib),
    .i_blank  (w_blank),
    .o_seg    (w_seg_dec)
  );

  // Slot timing, digit selection, leading-zero blanking and the next output values
  always_comb begin
    w_slot_end  = (r_pre == PRE_LAST);
    w_frame_end = w_slot_end && (r_idx == 2'd3);
    w_guard     = ({1'b0, r_pre} < GUARD_W);
    w_nib       = r_snap[{r_idx, 2'b00} +: 4];
    w_blank     = 1'b0;
    case (r_idx)
      2'd1:    w_blank = BLANK_LZ && (r_snap[15:4]  == 12'h000);
      2'd2:    w_blank = BLANK_LZ && (r_snap[15:8]  == 8'h00);
      2'd3:    w_blank = BLANK_LZ && (r_snap[15:12] == 4'h0);
      default: w_blank = 1'b0;
    endcase
    // Segments are also blanked in the guard window so nothing ghosts onto
    // the next digit while the anodes switch.
    w_an  = AN_OFF;
    w_seg = SEG_BLANK;
    if (!w_guard) begin
      w_an  = ~(4'b0001 << r_idx);
      w_seg = w_seg_dec;
    end
  end

  // Prescaler, digit index, per-frame snapshot and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pre   <= '0;
      r_idx   <= 2'd0;
      r_snap  <= 16'h0000;
      o_an    <= AN_OFF;
      o_seg   <= SEG_BLANK;
      o_frame <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_an    <= w_an;
      o_seg   <= w_seg;
      o_frame <= w_frame_end;
      if (w_slot_end) begin
        r_pre <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_pre <= r_pre + PW'(1);
      end
      // err tracks the snapshot, so it only changes when a snapshot is taken
      if (w_frame_end) begin
        r_snap <= i_dec;
        o_err  <= has_non_bcd(i_dec);
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with DIV=4.
// Main instance: GUARD=1, BLANK_LZ=1. Second instance: GUARD=0, BLANK_LZ=0, DEC=0.
module tb_bcd_scan_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_nb;
  logic [15:0] dec;
  logic [15:0] dec_nb;
  logic [3:0]  an, an_nb;
  logic [6:0]  seg, seg_nb;
  logic        frame, frame_nb;
  logic        err, err_nb;

  int n_chk   = 0;
  int n_err   = 0;
  int cyc     = 0;
  int nb_dark = 0;
  bit mon_en  = 1'b0;

  always #5 clk = ~clk;

  bcd_scan_display #(.DIV(4), .GUARD(1), .BLANK_LZ(1'b1)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_dec   (dec),
    .o_an    (an),
    .o_seg   (seg),
    .o_frame (frame),
    .o_err   (err)
  );

  bcd_scan_display #(.DIV(4), .GUARD(0), .BLANK_LZ(1'b0)) dut_nb (
    .i_clk   (clk),
    .i_rst   (rst_nb),
    .i_dec   (dec_nb),
    .o_an    (an_nb),
    .o_seg   (seg_nb),
    .o_frame (frame_nb),
    .o_err   (err_nb)
  );

  // With GUARD=0 the anodes must never go fully dark once scanning runs
  always @(negedge clk) begin
    if (mon_en && an_nb == 4'hF) nb_dark++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    chk({tag, "_an"}, {12'h0, an}, {12'h0, exp_an});
    chk({tag, "_seg"}, {9'h0, seg}, {9'h0, exp_seg});
  endtask

  initial begin
    rst    = 1'b1;
    rst_nb = 1'b1;
    dec    = 16'h1234;
    dec_nb = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    rst_nb = 1'b0;
    cyc    = 0;

    // cycle 0: reset values
    chk_disp("reset", 4'b1111, 7'h7F);
    chk("reset_frame", {15'h0, frame}, 16'h0);
    chk("reset_err", {15'h0, err}, 16'h0);
    chk("nb_reset_an", {12'h0, an_nb}, 16'h000F);

    // first frame shows snap=0 as "   0"
    go_to(1);
    chk("guard_c1_an", {12'h0, an}, 16'h000F);
    chk("nb_c1_an", {12'h0, an_nb}, 16'h000E);
    chk("nb_c1_seg", {9'h0, seg_nb}, 16'h0040);
    mon_en = 1'b1;
    go_to(2);  chk_disp("f0_d0", 4'b1110, 7'h40);
    go_to(5);  chk("nb_d1_an", {12'h0, an_nb}, 16'h000D);
               chk("nb_d1_seg", {9'h0, seg_nb}, 16'h0040);
    go_to(6);  chk_disp("f0_d1", 4'b1101, 7'h7F);
    go_to(9);  chk("nb_d2_an", {12'h0, an_nb}, 16'h000B);
               chk("nb_d2_seg", {9'h0, seg_nb}, 16'h0040);
    go_to(10); chk_disp("f0_d2", 4'b1011, 7'h7F);
    go_to(13); chk("nb_d3_an", {12'h0, an_nb}, 16'h0007);
               chk("nb_d3_seg", {9'h0, seg_nb}, 16'h0040);
    go_to(14); chk_disp("f0_d3", 4'b0111, 7'h7F);
    go_to(15); chk("frame_c15", {15'h0, frame}, 16'h0);

    // snapshot of 1234 taken at end of cycle 15
    go_to(16); chk("frame_c16", {15'h0, frame}, 16'h1);
               chk("err_c16", {15'h0, err}, 16'h0);
               chk("nb_frame_c16", {15'h0, frame_nb}, 16'h1);
    go_to(17); chk("guard_c17_an", {12'h0, an}, 16'h000F);
               chk("frame_c17", {15'h0, frame}, 16'h0);
    for (int c = 18; c <= 20; c++) begin
      go_to(c);
      chk_disp("f1_d0", 4'b1110, 7'h19);
    end
    dec = 16'h0045;
    go_to(22); chk_disp("f1_d1", 4'b1101, 7'h30);
    go_to(26); chk_disp("f1_d2", 4'b1011, 7'h24);
    go_to(30); chk_disp("f1_d3_no_tear", 4'b0111, 7'h79);

    // 0045 visible after the frame pulse at 32
    go_to(32); chk("frame_c32", {15'h0, frame}, 16'h1);
               chk("err_c32", {15'h0, err}, 16'h0);
    go_to(34); chk_disp("f2_d0", 4'b1110, 7'h12);
    go_to(36); dec = 16'h00A0;
    go_to(38); chk_disp("f2_d1", 4'b1101, 7'h19);
    go_to(42); chk_disp("f2_d2", 4'b1011, 7'h7F);
    go_to(46); chk_disp("f2_d3", 4'b0111, 7'h7F);

    // 00A0: dash on digit 1, err set with the frame pulse
    go_to(48); chk("frame_c48", {15'h0, frame}, 16'h1);
               chk("err_c48", {15'h0, err}, 16'h1);
    go_to(50); chk_disp("f3_d0", 4'b1110, 7'h40);
    go_to(52); dec = 16'h1111;
    go_to(54); chk_disp("f3_d1_dash", 4'b1101, 7'h3F);
    go_to(58); chk_disp("f3_d2", 4'b1011, 7'h7F);
    go_to(62); chk_disp("f3_d3", 4'b0111, 7'h7F);
               chk("err_hold_c62", {15'h0, err}, 16'h1);

    // 1111, then DEC changes to 2222 mid-frame at idx=1
    go_to(64); chk("err_clear_c64", {15'h0, err}, 16'h0);
               chk("frame_c64", {15'h0, frame}, 16'h1);
    go_to(66); chk_disp("f4_d0", 4'b1110, 7'h79);
    go_to(69); dec = 16'h2222;
    go_to(70); chk_disp("f4_d1", 4'b1101, 7'h79);
    go_to(74); chk_disp("f4_d2", 4'b1011, 7'h79);
    go_to(78); chk_disp("f4_d3", 4'b0111, 7'h79);
    go_to(80); chk("frame_c80", {15'h0, frame}, 16'h1);
    go_to(82); chk_disp("f5_d0", 4'b1110, 7'h24);
               dec = 16'h000B;
    go_to(86); chk_disp("f5_d1", 4'b1101, 7'h24);
    go_to(96); chk("err_c96", {15'h0, err}, 16'h1);
    go_to(100); chk("err_c100", {15'h0, err}, 16'h1);
                dec = 16'h0077;

    // one-cycle reset while idx=2
    go_to(105); rst = 1'b1;
    go_to(106); chk_disp("rst_mid", 4'b1111, 7'h7F);
                chk("rst_mid_frame", {15'h0, frame}, 16'h0);
                chk("rst_mid_err", {15'h0, err}, 16'h0);
                rst = 1'b0;
    go_to(108); chk_disp("post_rst_d0", 4'b1110, 7'h40);
    go_to(112); chk_disp("post_rst_d1", 4'b1101, 7'h7F);
    go_to(120); chk_disp("post_rst_d3", 4'b0111, 7'h7F);
    go_to(121); chk("post_rst_frame_c121", {15'h0, frame}, 16'h0);
    go_to(122); chk("post_rst_frame_c122", {15'h0, frame}, 16'h1);
    go_to(124); chk_disp("post_rst_f1_d0", 4'b1110, 7'h78);
    go_to(128); chk_disp("post_rst_f1_d1", 4'b1101, 7'h78);

    go_to(130);
    chk("nb_never_dark", nb_dark[15:0], 16'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
